cgra_launch_sequencer: RTL and testbench
========================================

// Module: cgra_launch_sequencer
// PURPOSE
// Register-bus initiator that launches one CGRA kernel through the CGRA peripheral register block.
// It takes a launch command, writes the per-column input/output pointers of the chosen slot, then writes
// the slot's kernel ID. It polls the kernel-ID register until the accelerator clears it (ack), then polls
// COL_STATUS until every requested column is free. Sits between a host-side DMA/controller and the CGRA reg bus.
// PARAMETERS
// CGRA_BASE      32'h0  byte base address of the CGRA register block
// OFF_KER_ID     32'h10 offset of SLOT0_KER_ID; slot s at OFF_KER_ID + 4*s
// OFF_PTR        32'h18 offset of SLOT0_PTR_IN_C0; PTR_IN cc = +8*c, PTR_OUT cc = +8*c+4, slot s adds SLOT_STRIDE*s
// SLOT_STRIDE    32'h40 byte stride between slot pointer banks
// OFF_COL_STATUS 32'h0C offset of COL_STATUS
// POLL_GAP       8      idle cycles between consecutive poll reads (>=1)
// MAX_POLLS      1024   reads per poll phase before timeout; 0 = never time out
// PORTS
// clk_i           in  1                     clock
// rst_i           in  1                     reset, synchronous, active-high
// cmd_valid_i     in  1                     launch command valid
// cmd_ready_o     out 1                     command accepted when valid&ready
// cmd_slot_i      in  N_SLOTS_LOG2          target slot
// cmd_ker_id_i    in  KER_CONF_N_REG_LOG2   kernel ID; 0 is illegal
// cmd_col_mask_i  in  N_COL                 columns used by the kernel
// cmd_ptr_in_i    in  N_COL*DP_WIDTH        input pointer per column, column c at [c*DP_WIDTH +: DP_WIDTH]
// cmd_ptr_out_i   in  N_COL*DP_WIDTH        output pointer per column, same packing
// reg_req_o       out reg_req_t             register-bus request (addr, write, wdata, wstrb, valid)
// reg_rsp_i       in  reg_rsp_t             register-bus response (rdata, error, ready)
// busy_o          out 1                     high from command accept until done_o
// done_o          out 1                     one-cycle pulse at end of a launch
// err_o           out 1                     valid with done_o: 1 = bus error, timeout or illegal command
// BEHAVIOUR
// - Reset: FSM=IDLE; reg_req_o='0; busy_o=0; done_o=0; err_o=0; cmd_ready_o=0 during reset and 1 only in IDLE.
// - Reset mid-transaction: the next cycle reg_req_o.valid=0, the command is discarded, and no done_o is issued.
// - Command and pointers are registered on accept; inputs are ignored afterwards.
// - Bus rule:
//   - valid is held with stable addr/write/wdata until ready=1; the transfer completes in the valid&ready cycle.
//   - valid=0 for at least 1 cycle between transfers.
//   - wstrb=4'hF on writes. Read data is sampled in the completing cycle.
// - States: IDLE -> WR_PTR -> WR_KER -> POLL_ACK -> POLL_END -> DONE -> IDLE.
// - Accept with cmd_ker_id_i==0 or cmd_col_mask_i==0: go directly to DONE, err=1, no bus traffic.
// - WR_PTR: for each set bit of the mask, ascending c, write PTR_IN then PTR_OUT (zero-extended to 32b).
//   Unset columns are skipped in zero cycles via a priority encoder on the remaining mask.
// - WR_KER: write cmd_ker_id to OFF_KER_ID + 4*slot. This write starts the kernel.
// - POLL_ACK: read the same KER_ID address every POLL_GAP+1 cycles; exit when rdata[KER_CONF_N_REG_LOG2-1:0]==0.
// - POLL_END: read COL_STATUS with the same spacing; exit when (rdata[N_COL-1:0] & mask)==0.
// - Poll counter resets on entry to each poll phase. If MAX_POLLS!=0 and MAX_POLLS reads complete without
//   the exit condition, go to DONE with err=1.
// - reg_rsp_i.error=1 on any completing transfer: abort, go to DONE with err=1, no further requests.
// - DONE: done_o=1 for one cycle; err_o=err for that cycle, 0 otherwise; busy_o drops the same cycle;
//   IDLE and cmd_ready_o=1 the next cycle.
// - Minimum latency, 1 column, ready combinational: accept + 2x(req+gap) + ker write + 1 ack read + 1 status read.
// - All address arithmetic is 32-bit, wrap-around unchecked.
// TESTING
// - Slot0, ker 3, mask 4'b0001, ptrs 0x100/0x200; responder acks on poll 2 and frees on poll 3 ->
//   writes 0x18=0x100, 0x1C=0x200, 0x10=3, then 2 KER_ID reads and 3 COL_STATUS reads; done_o=1, err_o=0.
// - Slot1, mask 4'b1010 -> exactly 5 writes in order: C1 in/out, C3 in/out (+SLOT_STRIDE), then 0x14; C0 and C2 untouched.
// - ready held low for 5 cycles on the first write -> addr/wdata stable for all 6 cycles; only one transfer counted.
// - error=1 on the KER_ID write -> no further valid; done_o with err_o=1.
// - MAX_POLLS=4, COL_STATUS never clears -> 4 status reads, then done_o with err_o=1; ker_id=0 command -> immediate done_o, err_o=1, no bus traffic.
// - rst_i asserted during POLL_END -> valid=0 next cycle, no done_o, cmd_ready_o=1 once rst_i drops.

Source files
------------

// File: rtl/cgra_launch_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// cgra_launch_sequencer : register-bus initiator that launches one CGRA kernel
// Revision              : 1.0
// ----------------------------------------------------------------------------
package cgra_launch_pkg;
  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        valid;
  } reg_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        error;
    logic        ready;
  } reg_rsp_t;
endpackage

module cgra_launch_sequencer
  import cgra_launch_pkg::*;
#(
  parameter int unsigned N_COL               = 4,
  parameter int unsigned N_SLOTS_LOG2        = 1,
  parameter int unsigned KER_CONF_N_REG_LOG2 = 4,
  parameter int unsigned DP_WIDTH            = 32,
  parameter logic [31:0] CGRA_BASE           = 32'h0,
  parameter logic [31:0] OFF_KER_ID          = 32'h10,
  parameter logic [31:0] OFF_PTR             = 32'h18,
  parameter logic [31:0] SLOT_STRIDE         = 32'h40,
  parameter logic [31:0] OFF_COL_STATUS      = 32'h0C,
  parameter int unsigned POLL_GAP            = 8,
  parameter int unsigned MAX_POLLS           = 1024
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           cmd_valid_i,
  output logic                           cmd_ready_o,
  input  logic [N_SLOTS_LOG2-1:0]        cmd_slot_i,
  input  logic [KER_CONF_N_REG_LOG2-1:0] cmd_ker_id_i,
  input  logic [N_COL-1:0]               cmd_col_mask_i,
  input  logic [N_COL*DP_WIDTH-1:0]      cmd_ptr_in_i,
  input  logic [N_COL*DP_WIDTH-1:0]      cmd_ptr_out_i,
  output reg_req_t                       reg_req_o,
  input  reg_rsp_t                       reg_rsp_i,
  output logic                           busy_o,
  output logic                           done_o,
  output logic                           err_o
);
  localparam int unsigned COL_W = (N_COL > 1) ? $clog2(N_COL) : 1;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_WR_PTR   = 3'd1;
  localparam logic [2:0] S_WR_KER   = 3'd2;
  localparam logic [2:0] S_POLL_ACK = 3'd3;
  localparam logic [2:0] S_POLL_END = 3'd4;
  localparam logic [2:0] S_DONE     = 3'd5;

  logic [2:0]                     state_q, state_d;
  logic [N_SLOTS_LOG2-1:0]        slot_q, slot_d;
  logic [KER_CONF_N_REG_LOG2-1:0] ker_q, ker_d;
  logic [N_COL-1:0]               mask_q, mask_d, rem_q, rem_d;
  logic [N_COL*DP_WIDTH-1:0]      ptr_in_q, ptr_in_d, ptr_out_q, ptr_out_d;
  logic                           phase_q, phase_d;
  logic [15:0]                    wait_q, wait_d;
  logic [31:0]                    poll_cnt_q, poll_cnt_d;
  logic                           err_q, err_d;

  logic [COL_W-1:0]    col;
  logic [DP_WIDTH-1:0] ptr_sel;
  logic [31:0]         ptr_ext;
  logic                req_valid, xfer, ack_seen, free_seen, poll_limit;
  logic                unused_rdata;

  // Lowest remaining column: unset columns cost no cycles.
  always_comb begin
    col = '0;
    for (int c = N_COL - 1; c >= 0; c--) begin
      if (rem_q[c]) col = COL_W'(c);
    end
  end

  assign ptr_sel      = phase_q ? ptr_out_q[col*DP_WIDTH +: DP_WIDTH] : ptr_in_q[col*DP_WIDTH +: DP_WIDTH];
  assign ack_seen     = (reg_rsp_i.rdata[KER_CONF_N_REG_LOG2-1:0] == '0);
  assign free_seen    = ((reg_rsp_i.rdata[N_COL-1:0] & mask_q) == '0);
  assign poll_limit   = (MAX_POLLS != 0) && ((poll_cnt_q + 32'd1) == MAX_POLLS);
  assign xfer         = req_valid & reg_rsp_i.ready;
  assign unused_rdata = ^reg_rsp_i.rdata;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      slot_q     <= '0;
      ker_q      <= '0;
      mask_q     <= '0;
      rem_q      <= '0;
      ptr_in_q   <= '0;
      ptr_out_q  <= '0;
      phase_q    <= 1'b0;
      wait_q     <= '0;
      poll_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      slot_q     <= slot_d;
      ker_q      <= ker_d;
      mask_q     <= mask_d;
      rem_q      <= rem_d;
      ptr_in_q   <= ptr_in_d;
      ptr_out_q  <= ptr_out_d;
      phase_q    <= phase_d;
      wait_q     <= wait_d;
      poll_cnt_q <= poll_cnt_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    slot_d     = slot_q;
    ker_d      = ker_q;
    mask_d     = mask_q;
    rem_d      = rem_q;
    ptr_in_d   = ptr_in_q;
    ptr_out_d  = ptr_out_q;
    phase_d    = phase_q;
    wait_d     = wait_q;
    poll_cnt_d = poll_cnt_q;
    err_d      = err_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid_i) begin
          slot_d     = cmd_slot_i;
          ker_d      = cmd_ker_id_i;
          mask_d     = cmd_col_mask_i;
          rem_d      = cmd_col_mask_i;
          ptr_in_d   = cmd_ptr_in_i;
          ptr_out_d  = cmd_ptr_out_i;
          phase_d    = 1'b0;
          wait_d     = '0;
          poll_cnt_d = '0;
          if (cmd_ker_id_i == '0 || cmd_col_mask_i == '0) begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            err_d   = 1'b0;
            state_d = S_WR_PTR;
          end
        end
      end
      S_WR_PTR, S_WR_KER, S_POLL_ACK, S_POLL_END: begin
        if (wait_q != '0) begin
          wait_d = wait_q - 16'd1;
        end else if (xfer) begin
          // Every completed transfer is followed by at least one idle bus cycle.
          wait_d = 16'd1;
          if (reg_rsp_i.error) begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            case (state_q)
              S_WR_PTR: begin
                phase_d = ~phase_q;
                if (phase_q) begin
                  rem_d = rem_q & ~(N_COL'(1) << col);
                  if ((rem_q & ~(N_COL'(1) << col)) == '0) state_d = S_WR_KER;
                end
              end
              S_WR_KER: begin
                poll_cnt_d = '0;
                state_d    = S_POLL_ACK;
              end
              S_POLL_ACK, S_POLL_END: begin
                if ((state_q == S_POLL_ACK) ? ack_seen : free_seen) begin
                  poll_cnt_d = '0;
                  state_d    = (state_q == S_POLL_ACK) ? S_POLL_END : S_DONE;
                end else if (poll_limit) begin
                  err_d   = 1'b1;
                  state_d = S_DONE;
                end else begin
                  poll_cnt_d = poll_cnt_q + 32'd1;
                  wait_d     = 16'(POLL_GAP);
                end
              end
              default: ;
            endcase
          end
        end
      end
      S_DONE: begin
        err_d   = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    reg_req_o     = '0;
    req_valid     = 1'b0;
    ptr_ext       = '0;
    ptr_ext[DP_WIDTH-1:0] = ptr_sel;
    case (state_q)
      S_WR_PTR: begin
        req_valid       = (wait_q == '0);
        reg_req_o.addr  = CGRA_BASE + OFF_PTR + SLOT_STRIDE * 32'(slot_q) + (32'(col) << 3)
                        + (phase_q ? 32'h4 : 32'h0);
        reg_req_o.write = 1'b1;
        reg_req_o.wdata = ptr_ext;
      end
      S_WR_KER: begin
        req_valid       = (wait_q == '0);
        reg_req_o.addr  = CGRA_BASE + OFF_KER_ID + (32'(slot_q) << 2);
        reg_req_o.write = 1'b1;
        reg_req_o.wdata = 32'(ker_q);
      end
      S_POLL_ACK: begin
        req_valid      = (wait_q == '0);
        reg_req_o.addr = CGRA_BASE + OFF_KER_ID + (32'(slot_q) << 2);
      end
      S_POLL_END: begin
        req_valid      = (wait_q == '0);
        reg_req_o.addr = CGRA_BASE + OFF_COL_STATUS;
      end
      default: ;
    endcase
    if (req_valid) begin
      reg_req_o.valid = 1'b1;
      reg_req_o.wstrb = reg_req_o.write ? 4'hF : 4'h0;
    end else begin
      reg_req_o = '0;
    end
    cmd_ready_o = (state_q == S_IDLE) && !rst_i;
    busy_o      = (state_q != S_IDLE) && (state_q != S_DONE);
    done_o      = (state_q == S_DONE);
    err_o       = (state_q == S_DONE) && err_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_cgra_launch_sequencer.sv
`default_nettype none
// Bench for cgra_launch_sequencer: directed and random launches checked
// against a transaction-list model of the expected register-bus traffic.
module tb_cgra_launch_sequencer;
  import cgra_launch_pkg::*;

  localparam int PG = 2;
  localparam int MP = 4;

  typedef struct {
    logic [31:0] addr;
    logic        write;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } xfer_t;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        cmd_valid_i = 1'b0;
  logic        cmd_ready_o;
  logic [0:0]  cmd_slot_i = '0;
  logic [3:0]  cmd_ker_id_i = '0;
  logic [3:0]  cmd_col_mask_i = '0;
  logic [63:0] cmd_ptr_in_i = '0;
  logic [63:0] cmd_ptr_out_i = '0;
  reg_req_t    req;
  reg_rsp_t    rsp = '0;
  logic        busy_o, done_o, err_o;

  cgra_launch_sequencer #(
    .N_COL(4), .N_SLOTS_LOG2(1), .KER_CONF_N_REG_LOG2(4), .DP_WIDTH(16),
    .POLL_GAP(PG), .MAX_POLLS(MP)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
    .cmd_slot_i(cmd_slot_i), .cmd_ker_id_i(cmd_ker_id_i), .cmd_col_mask_i(cmd_col_mask_i),
    .cmd_ptr_in_i(cmd_ptr_in_i), .cmd_ptr_out_i(cmd_ptr_out_i),
    .reg_req_o(req), .reg_rsp_i(rsp),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  xfer_t exp_q[$];
  xfer_t cap_q[$];

  // Responder plan for the current command
  int         p_ack_n, p_free_n, p_err_idx, p_delay0;
  bit         p_rnd;
  logic [0:0] p_slot;
  logic [3:0] p_ker, p_mask;
  int         cmd_seq = 0;

  // Expected traffic derived from the launch rules, one entry per completed transfer.
  task automatic build_expected(input logic [0:0] slot, input logic [3:0] ker, input logic [3:0] mask,
                                input logic [63:0] pin, input logic [63:0] pout,
                                input int ack_n, input int free_n, input int err_idx,
                                output logic exp_err);
    xfer_t t;
    bit    hit;
    exp_q.delete();
    exp_err = 1'b0;
    if (ker == 4'h0 || mask == 4'h0) begin
      exp_err = 1'b1;
      return;
    end
    t.write = 1'b1;
    t.wstrb = 4'hF;
    for (int c = 0; c < 4; c++) begin
      if (mask[c]) begin
        t.addr  = 32'h18 + 32'h40 * 32'(slot) + 32'(8 * c);
        t.wdata = {16'h0, pin[c*16 +: 16]};
        exp_q.push_back(t);
        t.addr  = t.addr + 32'h4;
        t.wdata = {16'h0, pout[c*16 +: 16]};
        exp_q.push_back(t);
      end
    end
    t.addr  = 32'h10 + 32'h4 * 32'(slot);
    t.wdata = 32'(ker);
    exp_q.push_back(t);
    t.write = 1'b0;
    t.wdata = '0;
    t.wstrb = '0;
    hit = 1'b0;
    for (int i = 1; i <= MP && !hit; i++) begin
      exp_q.push_back(t);
      if (i >= ack_n) hit = 1'b1;
    end
    if (!hit) exp_err = 1'b1;
    else begin
      t.addr = 32'h0C;
      hit = 1'b0;
      for (int i = 1; i <= MP && !hit; i++) begin
        exp_q.push_back(t);
        if (i >= free_n) hit = 1'b1;
      end
      if (!hit) exp_err = 1'b1;
    end
    if (err_idx >= 0 && err_idx < exp_q.size()) begin
      while (exp_q.size() > err_idx + 1) void'(exp_q.pop_back());
      exp_err = 1'b1;
    end
  endtask

  // Bus responder and protocol monitor, driven on the falling edge.
  int       ker_reads = 0, st_reads = 0, xfer_idx = 0, seen_seq = 0;
  int       hold_left = 0, idle_cnt = 0;
  bit       in_xfer = 0, last_done = 0, prev_rd = 0;
  logic [31:0] prev_rd_addr = '0;
  reg_req_t held;
  xfer_t    cap_t;

  always @(negedge clk_i) begin
    rsp.ready = 1'b0;
    rsp.error = 1'b0;
    rsp.rdata = $urandom;
    if (seen_seq != cmd_seq) begin
      seen_seq = cmd_seq;
      ker_reads = 0; st_reads = 0; xfer_idx = 0; prev_rd = 0;
      cap_q.delete();
    end
    if (rst_i) begin
      in_xfer = 0; last_done = 0; prev_rd = 0; idle_cnt = 0;
    end else begin
      if (last_done) check("bus_gap", 32'(req.valid), 32'd0);
      last_done = 0;
      if (!req.valid) idle_cnt++;
      else begin
        if (!in_xfer) begin
          in_xfer   = 1;
          held      = req;
          hold_left = (xfer_idx == 0) ? p_delay0 : (p_rnd ? int'($urandom_range(0, 2)) : 0);
          if (prev_rd && !req.write && req.addr == prev_rd_addr)
            check("poll_gap", 32'(idle_cnt), 32'(PG));
        end else begin
          check("hold_addr", req.addr, held.addr);
          check("hold_wdata", req.wdata, held.wdata);
          check("hold_write", 32'(req.write), 32'(held.write));
        end
        if (hold_left > 0) hold_left--;
        else begin
          rsp.ready = 1'b1;
          if (!req.write && req.addr == 32'h10 + 32'h4 * 32'(p_slot)) begin
            ker_reads++;
            rsp.rdata[3:0] = (ker_reads >= p_ack_n) ? 4'h0 : p_ker;
          end else if (!req.write && req.addr == 32'h0C) begin
            st_reads++;
            rsp.rdata[3:0] = (st_reads >= p_free_n) ? (rsp.rdata[3:0] & ~p_mask)
                                                    : (rsp.rdata[3:0] | p_mask);
          end
          rsp.error   = (xfer_idx == p_err_idx);
          cap_t.addr  = req.addr;
          cap_t.write = req.write;
          cap_t.wdata = req.wdata;
          cap_t.wstrb = req.wstrb;
          cap_q.push_back(cap_t);
          xfer_idx++;
          in_xfer = 0; last_done = 1; idle_cnt = 0;
          prev_rd = !req.write;
          prev_rd_addr = req.addr;
        end
      end
    end
  end

  task automatic issue_cmd(input string tag, input logic [0:0] slot, input logic [3:0] ker,
                           input logic [3:0] mask, input logic [63:0] pin, input logic [63:0] pout);
    int w = 0;
    @(negedge clk_i);
    cmd_valid_i = 1'b1; cmd_slot_i = slot; cmd_ker_id_i = ker; cmd_col_mask_i = mask;
    cmd_ptr_in_i = pin; cmd_ptr_out_i = pout;
    while (!cmd_ready_o && w < 20) begin
      @(negedge clk_i);
      w++;
    end
    if (!cmd_ready_o) begin
      n_tests++; n_fail++;
      $display("FAIL %s:accept got cmd_ready_o=0, expected 1", tag);
    end
    @(posedge clk_i);
    #1;
    // Inputs are scrambled after accept; the launch must use the registered copy.
    cmd_valid_i = 1'b0; cmd_slot_i = 1'($urandom); cmd_ker_id_i = 4'($urandom);
    cmd_col_mask_i = 4'($urandom); cmd_ptr_in_i = {$urandom, $urandom}; cmd_ptr_out_i = {$urandom, $urandom};
  endtask

  task automatic run_cmd(input string tag, input logic [0:0] slot, input logic [3:0] ker,
                         input logic [3:0] mask, input logic [63:0] pin, input logic [63:0] pout,
                         input int ack_n, input int free_n, input int err_idx, input int delay0, input bit rnd);
    logic exp_err;
    int   cyc = 0;
    bit   got = 0;
    int   n;
    build_expected(slot, ker, mask, pin, pout, ack_n, free_n, err_idx, exp_err);
    p_ack_n = ack_n; p_free_n = free_n; p_err_idx = err_idx; p_delay0 = delay0; p_rnd = rnd;
    p_slot = slot; p_ker = ker; p_mask = mask;
    cmd_seq++;
    issue_cmd(tag, slot, ker, mask, pin, pout);
    while (!got && cyc < 400) begin
      @(negedge clk_i);
      cyc++;
      if (done_o) got = 1;
      else if (cyc == 1) check({tag, ":busy"}, 32'(busy_o), 32'd1);
    end
    if (!got) begin
      n_tests++; n_fail++;
      $display("FAIL %s:done got no done_o, expected done_o within 400 cycles", tag);
    end else begin
      check({tag, ":err"}, 32'(err_o), 32'(exp_err));
      check({tag, ":busy_at_done"}, 32'(busy_o), 32'd0);
      if (ker == 4'h0 || mask == 4'h0) check({tag, ":latency"}, 32'(cyc), 32'd1);
      @(negedge clk_i);
      check({tag, ":done_pulse"}, 32'(done_o), 32'd0);
      check({tag, ":err_after"}, 32'(err_o), 32'd0);
      check({tag, ":ready_after"}, 32'(cmd_ready_o), 32'd1);
    end
    check({tag, ":n_xfer"}, 32'(cap_q.size()), 32'(exp_q.size()));
    n = (cap_q.size() < exp_q.size()) ? cap_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check({tag, ":addr"}, cap_q[i].addr, exp_q[i].addr);
      check({tag, ":write"}, 32'(cap_q[i].write), 32'(exp_q[i].write));
      if (exp_q[i].write) begin
        check({tag, ":wdata"}, cap_q[i].wdata, exp_q[i].wdata);
        check({tag, ":wstrb"}, 32'(cap_q[i].wstrb), 32'(exp_q[i].wstrb));
      end
    end
  endtask

  initial begin
    int w, bad;
    p_ack_n = 1; p_free_n = 1; p_err_idx = -1; p_delay0 = 0; p_rnd = 0;
    p_slot = '0; p_ker = '0; p_mask = '0;
    repeat (3) @(negedge clk_i);
    check("rst_valid", 32'(req.valid), 32'd0);
    check("rst_addr", req.addr, 32'd0);
    check("rst_cmd_ready", 32'(cmd_ready_o), 32'd0);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_done", 32'(done_o), 32'd0);
    check("rst_err", 32'(err_o), 32'd0);
    @(posedge clk_i);
    #1 rst_i = 1'b0;
    @(negedge clk_i);
    check("idle_cmd_ready", 32'(cmd_ready_o), 32'd1);

    run_cmd("basic", 1'b0, 4'd3, 4'b0001, 64'h0100, 64'h0200, 2, 3, -1, 0, 0);
    run_cmd("mask1010", 1'b1, 4'd5, 4'b1010, {$urandom, $urandom}, {$urandom, $urandom}, 1, 1, -1, 0, 0);
    run_cmd("hold5", 1'b0, 4'd9, 4'b0011, {$urandom, $urandom}, {$urandom, $urandom}, 1, 1, -1, 5, 0);
    run_cmd("ker_wr_err", 1'b0, 4'd4, 4'b0001, {$urandom, $urandom}, {$urandom, $urandom}, 1, 1, 2, 0, 0);
    run_cmd("status_timeout", 1'b1, 4'd6, 4'b1111, {$urandom, $urandom}, {$urandom, $urandom}, 1, 100, -1, 0, 1);
    run_cmd("ack_timeout", 1'b0, 4'd2, 4'b0100, {$urandom, $urandom}, {$urandom, $urandom}, 100, 1, -1, 0, 0);
    run_cmd("ker0", 1'b1, 4'd0, 4'b0110, {$urandom, $urandom}, {$urandom, $urandom}, 1, 1, -1, 0, 0);
    run_cmd("mask0", 1'b0, 4'd5, 4'b0000, {$urandom, $urandom}, {$urandom, $urandom}, 1, 1, -1, 0, 0);

    for (int k = 0; k < 25; k++) begin
      run_cmd("rand", 1'($urandom), 4'($urandom), 4'($urandom), {$urandom, $urandom}, {$urandom, $urandom},
              int'($urandom_range(1, 5)), int'($urandom_range(1, 5)),
              ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : -1, int'($urandom_range(0, 3)), 1);
    end

    // Reset while polling COL_STATUS
    p_ack_n = 1; p_free_n = 100; p_err_idx = -1; p_delay0 = 0; p_rnd = 0;
    p_slot = 1'b0; p_ker = 4'd7; p_mask = 4'b0100;
    cmd_seq++;
    issue_cmd("rst_mid", 1'b0, 4'd7, 4'b0100, {$urandom, $urandom}, {$urandom, $urandom});
    w = 0;
    while (st_reads < 2 && w < 200) begin
      @(negedge clk_i);
      w++;
    end
    check("rst_mid:reached_poll_end", 32'(st_reads >= 2), 32'd1);
    @(posedge clk_i);
    #1 rst_i = 1'b1;
    @(negedge clk_i);
    check("rst_mid:valid", 32'(req.valid), 32'd0);
    check("rst_mid:done", 32'(done_o), 32'd0);
    check("rst_mid:ready_in_rst", 32'(cmd_ready_o), 32'd0);
    @(posedge clk_i);
    #1 rst_i = 1'b0;
    @(negedge clk_i);
    check("rst_mid:ready_after", 32'(cmd_ready_o), 32'd1);
    check("rst_mid:busy_after", 32'(busy_o), 32'd0);
    bad = 0;
    repeat (20) begin
      @(negedge clk_i);
      if (done_o || req.valid) bad++;
    end
    check("rst_mid:quiet", 32'(bad), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
